mod_count_checker: RTL and testbench
====================================

Name: mod_count_checker

Overview:
- Receive-side monitor for the synchronous mod-N counter output bus (default mod-5, 3 bits).
- Samples the incoming count when valid is high and locks onto the sequence 0,1,...,MODULUS-1,0,...
- Flags sequence errors and keeps a saturating error tally.
- Sits at the consumer end of any counter-driven interface, such as a slot or phase index, and provides a lock indication to downstream logic.

Parameters:
- MODULUS, 5, count modulus; legal values are 0..MODULUS-1.
- WIDTH, 3, width of the count bus; must satisfy 2**WIDTH >= MODULUS.
- LOCK_COUNT, 3, number of consecutive correct transitions required to declare lock.
- ERR_LIMIT, 2, number of consecutive mismatches while locked that drops lock.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk, input, 1, the single clock; all state changes on the rising edge.
- rst, input, 1, synchronous, active-high reset; sampled on the rising edge of clk.
- valid, input, 1, marks cnt_in as a sample this cycle.
- cnt_in, input, WIDTH, received count value.
- locked, output, 1, high while in the LOCKED state.
- expected, output, WIDTH, next value predicted; 0 when not in SYNC or LOCKED.
- err_pulse, output, 1, one-cycle pulse on a mismatch while locked.
- wrap_pulse, output, 1, one-cycle pulse when a correct MODULUS-1 to 0 transition is accepted while locked.
- err_count, output, ERR_CNT_W, saturating count of err_pulse events.

Behaviour:
- Reset:
  - rst is synchronous and active-high, and overrides everything else.
  - On the clock edge where rst=1: state goes to HUNT; locked, expected, err_pulse, wrap_pulse and err_count all go to 0; internal good and bad counters go to 0.
  - Reset mid-operation (any state) behaves identically.
- Timing:
  - All outputs are registered.
  - The response to a sample appears on the clock edge that samples it, so it is visible in the following cycle.
- Idle cycles:
  - valid=0 means no state change; err_pulse and wrap_pulse are 0; expected holds.
- Helper definitions:
  - nxt(x) = 0 if x == MODULUS-1, else x+1.
  - A value is illegal if cnt_in >= MODULUS.
- HUNT:
  - On valid with a legal cnt_in: expected <= nxt(cnt_in), good <= 0, go to SYNC.
  - Illegal values are ignored; stay in HUNT.
- SYNC:
  - On valid with cnt_in == expected:
    - good <= good+1 and expected <= nxt(cnt_in).
    - If good+1 == LOCK_COUNT: go to LOCKED, locked <= 1, bad <= 0.
  - On valid with a legal mismatch: restart; expected <= nxt(cnt_in), good <= 0, stay in SYNC.
  - On valid with an illegal value: go to HUNT, expected <= 0.
  - No err_pulse is ever generated in SYNC.
- LOCKED, match (cnt_in == expected):
  - bad <= 0; expected <= nxt(expected).
  - wrap_pulse <= 1 if cnt_in == 0.
- LOCKED, mismatch (including illegal values):
  - err_pulse <= 1; err_count increments, saturating at all-ones.
  - Flywheel: expected <= nxt(expected), so the received value is not adopted.
  - bad <= bad+1.
  - If bad+1 == ERR_LIMIT: go to HUNT, locked <= 0, expected <= 0, bad <= 0.
  - err_pulse is still asserted on this final edge.
- err_count:
  - Cleared only by rst; never wraps.
- Simultaneous events:
  - A wrap and an error cannot coincide, since a wrap requires a match.
  - rst together with valid: reset wins and the sample is discarded.
- Edge case:
  - With LOCK_COUNT=1, the first correct transition after HUNT locks.

Test Plan:
- Lock-up: rst, then valid samples 0,1,2,3 on consecutive cycles.
  - locked=0 after samples 0,1,2; locked=1 after sample 3; expected=4.
- Wrap: locked, then samples 4,0,1.
  - wrap_pulse=1 for exactly the cycle after sample 0; err_pulse stays 0; expected=2 at the end.
- Single glitch with flywheel: locked expecting 1, then samples 3,2.
  - err_pulse=1 once; err_count=1; expected=2 after the glitch; sample 2 matches; locked stays 1.
- Loss of lock: locked expecting 2, then samples 7,7.
  - err_pulse on both cycles; err_count +2; locked=0 after the second sample; expected=0; then samples 1,2,3,4 re-lock.
- Illegal and gap handling:
  - In HUNT, samples 5,6,7 leave state and outputs at 0.
  - valid=0 gaps between samples 0 and 1 in SYNC do not break the lock count.
- Reset and saturation:
  - With ERR_CNT_W=2, four errors give err_count=3, held at 3.
  - Asserting rst while locked gives all outputs 0 on the next edge, and a sample presented during rst is ignored.

Source files
------------

// File: rtl/mod_count_checker.sv
// Receive-side monitor for a mod-N counter bus: locks onto 0..MODULUS-1,
// flags sequence errors while locked, and keeps a saturating error tally.
module mod_count_checker #(
  parameter int MODULUS    = 5,
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     cnt_in,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  // state  | meaning
  // HUNT   | no reference yet; waiting for any legal sample
  // SYNC   | tracking a candidate sequence, counting correct transitions
  // LOCKED | sequence confirmed; mismatches are flagged and flywheeled over
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int GOOD_W = ($clog2(LOCK_COUNT + 1) > 0) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int BAD_W  = ($clog2(ERR_LIMIT + 1) > 0)  ? $clog2(ERR_LIMIT + 1)  : 1;

  localparam logic [WIDTH:0]    MOD_EXT  = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0]  LAST     = MOD_EXT[WIDTH-1:0] - 1'b1;
  localparam logic [GOOD_W-1:0] GOOD_LIM = LOCK_COUNT[GOOD_W-1:0];
  localparam logic [BAD_W-1:0]  BAD_LIM  = ERR_LIMIT[BAD_W-1:0];

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  state_t               state, state_n;
  logic [GOOD_W-1:0]    good, good_n, good_inc;
  logic [BAD_W-1:0]     bad, bad_n, bad_inc;
  logic                 locked_n, err_pulse_n, wrap_pulse_n;
  logic [WIDTH-1:0]     expected_n;
  logic [ERR_CNT_W-1:0] err_count_n;
  logic                 legal, match;

  assign legal    = ({1'b0, cnt_in} < MOD_EXT);
  assign match    = (cnt_in == expected);
  assign good_inc = good + 1'b1;
  assign bad_inc  = bad + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      good       <= '0;
      bad        <= '0;
      locked     <= 1'b0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      good       <= good_n;
      bad        <= bad_n;
      locked     <= locked_n;
      expected   <= expected_n;
      err_pulse  <= err_pulse_n;
      wrap_pulse <= wrap_pulse_n;
      err_count  <= err_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    good_n       = good;
    bad_n        = bad;
    locked_n     = locked;
    expected_n   = expected;
    err_pulse_n  = 1'b0;
    wrap_pulse_n = 1'b0;
    err_count_n  = err_count;

    if (valid) begin
      unique case (state)
        HUNT: begin
          if (legal) begin
            expected_n = nxt(cnt_in);
            good_n     = '0;
            state_n    = SYNC;
          end
        end

        SYNC: begin
          if (!legal) begin
            expected_n = '0;
            good_n     = '0;
            state_n    = HUNT;
          end else if (match) begin
            good_n     = good_inc;
            expected_n = nxt(cnt_in);
            if (good_inc == GOOD_LIM) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              bad_n    = '0;
            end
          end else begin
            expected_n = nxt(cnt_in);
            good_n     = '0;
          end
        end

        LOCKED: begin
          if (match) begin
            bad_n        = '0;
            expected_n   = nxt(expected);
            wrap_pulse_n = (cnt_in == '0);
          end else begin
            // Flywheel: keep predicting from our own sequence, not the bad sample.
            err_pulse_n = 1'b1;
            if (err_count != '1) err_count_n = err_count + 1'b1;
            expected_n  = nxt(expected);
            bad_n       = bad_inc;
            if (bad_inc == BAD_LIM) begin
              state_n    = HUNT;
              locked_n   = 1'b0;
              expected_n = '0;
              bad_n      = '0;
              good_n     = '0;
            end
          end
        end

        default: begin
          state_n    = HUNT;
          locked_n   = 1'b0;
          expected_n = '0;
          good_n     = '0;
          bad_n      = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_count_checker.sv
// Directed bench for mod_count_checker: default instance plus variants with a
// 2-bit error counter and with LOCK_COUNT=1, all driven by the same stimulus.
module tb_mod_count_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [2:0] cnt_in;

  logic       locked, err_pulse, wrap_pulse;
  logic [2:0] expected;
  logic [7:0] err_count;

  logic       s_locked, s_err_pulse, s_wrap_pulse;
  logic [2:0] s_expected;
  logic [1:0] s_err_count;

  logic       l_locked, l_err_pulse, l_wrap_pulse;
  logic [2:0] l_expected;
  logic [7:0] l_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_count_checker u_dut (
    .clk(clk), .rst(rst), .valid(valid), .cnt_in(cnt_in),
    .locked(locked), .expected(expected), .err_pulse(err_pulse),
    .wrap_pulse(wrap_pulse), .err_count(err_count)
  );

  mod_count_checker #(.ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .valid(valid), .cnt_in(cnt_in),
    .locked(s_locked), .expected(s_expected), .err_pulse(s_err_pulse),
    .wrap_pulse(s_wrap_pulse), .err_count(s_err_count)
  );

  mod_count_checker #(.LOCK_COUNT(1)) u_lc1 (
    .clk(clk), .rst(rst), .valid(valid), .cnt_in(cnt_in),
    .locked(l_locked), .expected(l_expected), .err_pulse(l_err_pulse),
    .wrap_pulse(l_wrap_pulse), .err_count(l_err_count)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    valid  = 1'b1;
    cnt_in = v;
    @(posedge clk);
    #1;
    valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v, input logic [2:0] c);
    rst    = 1'b1;
    valid  = v;
    cnt_in = c;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    valid  = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    valid  = 1'b0;
    cnt_in = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 3'd0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_expected", int'(expected), 0);
    check_eq("rst_err_count", int'(err_count), 0);

    // Lock-up 0,1,2,3
    drive(3'd0); check_eq("lk0_locked", int'(locked), 0); check_eq("lk0_exp", int'(expected), 1);
    drive(3'd1); check_eq("lk1_locked", int'(locked), 0);
    check_eq("lc1_locked", int'(l_locked), 1);
    drive(3'd2); check_eq("lk2_locked", int'(locked), 0);
    drive(3'd3); check_eq("lk3_locked", int'(locked), 1); check_eq("lk3_exp", int'(expected), 4);

    // Wrap 4,0,1
    drive(3'd4); check_eq("wr4_wrap", int'(wrap_pulse), 0); check_eq("wr4_err", int'(err_pulse), 0);
    drive(3'd0); check_eq("wr0_wrap", int'(wrap_pulse), 1); check_eq("wr0_err", int'(err_pulse), 0);
    drive(3'd1); check_eq("wr1_wrap", int'(wrap_pulse), 0); check_eq("wr1_exp", int'(expected), 2);

    // Advance to expecting 1, then glitch 3 and recover on 2
    drive(3'd2); drive(3'd3); drive(3'd4); drive(3'd0);
    check_eq("pre_gl_exp", int'(expected), 1);
    drive(3'd3);
    check_eq("gl_err", int'(err_pulse), 1);
    check_eq("gl_cnt", int'(err_count), 1);
    check_eq("gl_exp", int'(expected), 2);
    check_eq("gl_locked", int'(locked), 1);
    drive(3'd2);
    check_eq("gl2_err", int'(err_pulse), 0);
    check_eq("gl2_locked", int'(locked), 1);
    check_eq("gl2_exp", int'(expected), 3);

    // Advance to expecting 2, then lose lock with 7,7
    drive(3'd3); drive(3'd4); drive(3'd0); drive(3'd1);
    check_eq("pre_loss_exp", int'(expected), 2);
    drive(3'd7);
    check_eq("loss1_err", int'(err_pulse), 1);
    check_eq("loss1_locked", int'(locked), 1);
    drive(3'd7);
    check_eq("loss2_err", int'(err_pulse), 1);
    check_eq("loss2_cnt", int'(err_count), 3);
    check_eq("loss2_locked", int'(locked), 0);
    check_eq("loss2_exp", int'(expected), 0);
    drive(3'd1); drive(3'd2); drive(3'd3);
    check_eq("rel3_locked", int'(locked), 0);
    drive(3'd4);
    check_eq("rel4_locked", int'(locked), 1);
    check_eq("rel4_exp", int'(expected), 0);

    // Saturation on the 2-bit counter instance: errors 4 and 5
    drive(3'd7);
    check_eq("sat4_main", int'(err_count), 4);
    check_eq("sat4_small", int'(s_err_count), 3);
    drive(3'd7);
    check_eq("sat5_small", int'(s_err_count), 3);
    check_eq("sat5_locked", int'(locked), 0);

    // Re-lock, glitch to raise err_pulse, then reset with a sample present
    drive(3'd0); drive(3'd1); drive(3'd2); drive(3'd3);
    check_eq("rl_locked", int'(locked), 1);
    drive(3'd7);
    check_eq("rl_err", int'(err_pulse), 1);
    check_eq("rl_cnt", int'(err_count), 6);
    do_reset(1'b1, 3'd4);
    check_eq("mr_locked", int'(locked), 0);
    check_eq("mr_exp", int'(expected), 0);
    check_eq("mr_err", int'(err_pulse), 0);
    check_eq("mr_wrap", int'(wrap_pulse), 0);
    check_eq("mr_cnt", int'(err_count), 0);
    check_eq("mr_small_cnt", int'(s_err_count), 0);
    drive(3'd3);
    check_eq("post_rst_exp", int'(expected), 4);
    check_eq("post_rst_locked", int'(locked), 0);

    // Illegal values in HUNT are ignored
    do_reset(1'b0, 3'd0);
    for (int v = 5; v <= 7; v++) begin
      drive(3'(v));
      check_eq("hunt_ill_exp", int'(expected), 0);
      check_eq("hunt_ill_locked", int'(locked), 0);
    end

    // Gaps in SYNC do not disturb the good count
    drive(3'd0);
    idle(3);
    check_eq("gap_exp", int'(expected), 1);
    drive(3'd1);
    idle(2);
    drive(3'd2);
    check_eq("gap2_locked", int'(locked), 0);
    drive(3'd3);
    check_eq("gap3_locked", int'(locked), 1);
    check_eq("gap3_exp", int'(expected), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
